// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file write port.
// One holding slot per source, oldest-first drain, per-address busy flags for hazard stalls.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic              busy_1,
  output logic              busy_2
);

  typedef enum logic [1:0] {
    AGE_TIE     = 2'd0,
    AGE_ALU_OLD = 2'd1,
    AGE_MEM_OLD = 2'd2
  } age_e;

  logic              alu_full, mem_full;
  logic [ADDR_W-1:0] alu_rd, mem_rd;
  logic [DATA_W-1:0] alu_dat, mem_dat;
  age_e              age_q, age_d;
  logic              rr_q, rr_d;

  logic alu_grant, mem_grant;
  logic alu_fill, mem_fill;
  logic alu_stays, mem_stays;

  // Grant selection: older slot wins; on a tie, same-register goes MEM then ALU, else round-robin.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    rr_d      = rr_q;
    if (alu_full && mem_full) begin
      case (age_q)
        AGE_ALU_OLD: alu_grant = 1'b1;
        AGE_MEM_OLD: mem_grant = 1'b1;
        default: begin
          if (alu_rd == mem_rd) begin
            mem_grant = 1'b1;
          end else begin
            if (rr_q) mem_grant = 1'b1;
            else      alu_grant = 1'b1;
            rr_d = ~rr_q;
          end
        end
      endcase
    end else begin
      alu_grant = alu_full;
      mem_grant = mem_full;
    end
  end

  assign alu_ready = !rst && (!alu_full || alu_grant);
  assign mem_ready = !rst && (!mem_full || mem_grant);

  // R0 requests complete the handshake but never occupy a slot.
  assign alu_fill  = alu_valid && alu_ready && (alu_reg != '0);
  assign mem_fill  = mem_valid && mem_ready && (mem_reg != '0);
  assign alu_stays = alu_full && !alu_grant;
  assign mem_stays = mem_full && !mem_grant;

  // Relative age: a slot filled while the other stays occupied is the younger one.
  always_comb begin
    age_d = age_q;
    if (alu_fill && mem_fill)       age_d = AGE_TIE;
    else if (alu_fill && mem_stays) age_d = AGE_MEM_OLD;
    else if (mem_fill && alu_stays) age_d = AGE_ALU_OLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_full         <= 1'b0;
      alu_rd           <= '0;
      alu_dat          <= '0;
      mem_full         <= 1'b0;
      mem_rd           <= '0;
      mem_dat          <= '0;
      age_q            <= AGE_TIE;
      rr_q             <= 1'b0;
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
    end else begin
      age_q <= age_d;
      rr_q  <= rr_d;

      if (alu_fill) begin
        alu_full <= 1'b1;
        alu_rd   <= alu_reg;
        alu_dat  <= alu_data;
      end else if (alu_grant) begin
        alu_full <= 1'b0;
      end

      if (mem_fill) begin
        mem_full <= 1'b1;
        mem_rd   <= mem_reg;
        mem_dat  <= mem_data;
      end else if (mem_grant) begin
        mem_full <= 1'b0;
      end

      signal_reg_write <= alu_grant || mem_grant;
      if (mem_grant) begin
        write_reg  <= mem_rd;
        write_data <= mem_dat;
      end else if (alu_grant) begin
        write_reg  <= alu_rd;
        write_data <= alu_dat;
      end
    end
  end

  // A read address is busy while any pending or just-registered write targets it.
  assign busy_1 = (read_reg_1 != '0) &&
                  ((alu_full && alu_rd == read_reg_1) ||
                   (mem_full && mem_rd == read_reg_1) ||
                   (signal_reg_write && write_reg == read_reg_1));
  assign busy_2 = (read_reg_2 != '0) &&
                  ((alu_full && alu_rd == read_reg_2) ||
                   (mem_full && mem_rd == read_reg_2) ||
                   (signal_reg_write && write_reg == read_reg_2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed write-port sequences and busy flags.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              signal_reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg_1 = '0;
  logic [ADDR_W-1:0] read_reg_2 = '0;
  logic              busy_1;
  logic              busy_2;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .signal_reg_write(signal_reg_write), .write_reg(write_reg), .write_data(write_data),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .busy_1(busy_1), .busy_2(busy_2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write-port cycle: pulse, address, data.
  task automatic check_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_we"},   32'(signal_reg_write), 32'd1);
    check({tag, "_reg"},  32'(write_reg), 32'(r));
    check({tag, "_data"}, write_data, d);
  endtask

  initial begin
    // 1: reset
    tick(); tick();
    check("rst_we", 32'(signal_reg_write), 32'd0);
    check("rst_wreg", 32'(write_reg), 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("post_rst_mem_ready", 32'(mem_ready), 32'd1);

    // 2: single ALU write with busy tracking
    read_reg_1 = 5'd5;
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    check("t2_busy_before", 32'(busy_1), 32'd0);
    tick();
    alu_valid = 1'b0;
    check("t2_we_accept", 32'(signal_reg_write), 32'd0);
    check("t2_busy_slot", 32'(busy_1), 32'd1);
    tick();
    check_wr("t2_write", 5'd5, 32'hDEADBEEF);
    check("t2_busy_out", 32'(busy_1), 32'd1);
    tick();
    check("t2_we_done", 32'(signal_reg_write), 32'd0);
    check("t2_busy_clear", 32'(busy_1), 32'd0);
    check("t2_wreg_held", 32'(write_reg), 32'd5);

    // 3: simultaneous different registers, round-robin alternates
    read_reg_1 = 5'd0; read_reg_2 = 5'd4;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'd1;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'd2;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("t3_busy2", 32'(busy_2), 32'd1);
    tick(); check_wr("t3a_first", 5'd3, 32'd1);
    tick(); check_wr("t3a_second", 5'd4, 32'd2);
    tick(); check("t3a_idle", 32'(signal_reg_write), 32'd0);
    check("t3_busy2_clear", 32'(busy_2), 32'd0);
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'd5;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'd6;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick(); check_wr("t3b_first", 5'd4, 32'd6);
    tick(); check_wr("t3b_second", 5'd3, 32'd5);
    tick(); check("t3b_idle", 32'(signal_reg_write), 32'd0);

    // 4: same register on the same edge -> MEM then ALU
    read_reg_2 = 5'd0;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hA;
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'hB;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick(); check_wr("t4_first", 5'd7, 32'hB);
    tick(); check_wr("t4_final", 5'd7, 32'hA);
    tick(); check("t4_idle", 32'(signal_reg_write), 32'd0);

    // Age ordering with refills of granted slots (rr=0 here)
    alu_valid = 1'b1; alu_reg = 5'd16; alu_data = 32'h16;
    mem_valid = 1'b1; mem_reg = 5'd17; mem_data = 32'h17;
    tick();
    alu_reg = 5'd18; alu_data = 32'h18; mem_valid = 1'b0;
    check("age_alu_refill_ready", 32'(alu_ready), 32'd1);
    check("age_mem_not_ready", 32'(mem_ready), 32'd0);
    tick();
    check_wr("age_w16", 5'd16, 32'h16);
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd19; mem_data = 32'h19;
    check("age_mem_refill_ready", 32'(mem_ready), 32'd1);
    tick();
    check_wr("age_w17", 5'd17, 32'h17);
    mem_valid = 1'b0;
    tick(); check_wr("age_w18", 5'd18, 32'h18);
    tick(); check_wr("age_w19", 5'd19, 32'h19);
    tick(); check("age_idle", 32'(signal_reg_write), 32'd0);

    // 5: R0 request handshakes but never writes or flags busy
    read_reg_1 = 5'd0;
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h55;
    check("t5_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    check("t5_busy_r0", 32'(busy_1), 32'd0);
    check("t5_mem_ready_after", 32'(mem_ready), 32'd1);
    tick();
    check("t5_no_we", 32'(signal_reg_write), 32'd0);
    check("t5_wreg_held", 32'(write_reg), 32'd19);

    // 6: reset mid-operation discards the in-flight pulse and the full slot
    read_reg_1 = 5'd11; read_reg_2 = 5'd9;
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
    tick();
    alu_reg = 5'd11; alu_data = 32'h11;
    tick();
    alu_valid = 1'b0;
    check_wr("t6_inflight", 5'd9, 32'h99);
    check("t6_busy_slot", 32'(busy_1), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_ready_in_rst", 32'(alu_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("t6_we_cleared", 32'(signal_reg_write), 32'd0);
    check("t6_wreg_cleared", 32'(write_reg), 32'd0);
    check("t6_busy1_cleared", 32'(busy_1), 32'd0);
    check("t6_busy2_cleared", 32'(busy_2), 32'd0);
    #1;
    check("t6_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    check("t6_no_we_after", 32'(signal_reg_write), 32'd0);
    tick();
    check("t6_still_idle", 32'(signal_reg_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
